// File: rtl/uart_rx_framer.sv
// UART receive framer: 8N1 deserializer with a one-deep output holding
// register, ready/valid handshake, frame-error pulse and sticky overrun.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | line idle, waiting for rx_s to fall
// START | timing to the middle of the start bit to confirm it
// DATA  | sampling 8 data bits at mid-bit, LSB first
// STOP  | sampling the stop bit at mid-bit
// BREAK | stop bit was low; waiting for the line to return high
module uart_rx_framer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    // Mid-bit offset for the start bit and full-bit terminal count thereafter.
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t      state;
    logic        rx_meta;
    logic        rx_s;
    logic [15:0] timer;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        byte_done;
    logic        handshake;

    assign busy      = (state != IDLE);
    assign handshake = rx_valid && rx_ready;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Framing FSM: bit timing, deserialization, stop-bit check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= 16'd0;
            bit_idx   <= 3'd0;
            shreg     <= 8'h00;
            byte_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        timer <= 16'd0;
                    end
                end
                START: begin
                    if (timer == HALF_LAST) begin
                        timer   <= 16'd0;
                        bit_idx <= 3'd0;
                        // A line that is already back high was only a glitch.
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                DATA: begin
                    if (timer == BIT_LAST) begin
                        timer   <= 16'd0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                STOP: begin
                    if (timer == BIT_LAST) begin
                        timer <= 16'd0;
                        if (rx_s) begin
                            byte_done <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    timer <= 16'd0;
                end
            endcase
        end
    end

    // Output holding register: load on completion when free or being
    // drained this cycle, otherwise drop the new byte and flag overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else if (byte_done) begin
            if (!rx_valid || rx_ready) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
                if (handshake) begin
                    overrun <= 1'b0;
                end
            end else begin
                overrun <= 1'b1;
            end
        end else if (handshake) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Self-checking bench for uart_rx_framer with a byte scoreboard.
module tb_uart_rx_framer;

    localparam int C   = 16;
    localparam int LAT = 2 + C / 2 + 9 * C + 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx_framer #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] sb[$];
    int n_chk = 0;
    int n_pass = 0;
    int fe_cnt = 0;
    int vc = 0;
    int last_rise = 0;
    int t_start = 0;
    logic prev_valid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Inputs change 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        tick();
        rx = 1'b0;
        t_start = cyc;
        repeat (C) tick();
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (C) tick();
        end
        rx = stop_bit;
        repeat (C) tick();
    endtask

    // Output monitor: pulse/level counters and scoreboard pop on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (frame_err) fe_cnt++;
            if (rx_valid) vc++;
            if (rx_valid && !prev_valid) last_rise = cyc;
            prev_valid = rx_valid;
            if (rx_valid && rx_ready && rst_n) begin
                chk("sb_pending", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) chk("rx_data", 32'(rx_data), 32'(sb.pop_front()));
            end
        end
    end

    int fe0, vc0;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rx_data", 32'(rx_data), 32'h00);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // Clean frame, consumer always ready
        rx_ready = 1'b1;
        fe0 = fe_cnt; vc0 = vc;
        sb.push_back(8'hA5);
        send_byte(8'hA5, 1'b1);
        repeat (20) tick();
        chk("t1_latency", 32'(last_rise - t_start), 32'(LAT));
        chk("t1_valid_width", 32'(vc - vc0), 32'd1);
        chk("t1_frame_err", 32'(fe_cnt - fe0), 32'd0);
        chk("t1_overrun", 32'(overrun), 32'd0);
        chk("t1_drained", 32'(sb.size()), 32'd0);

        // Short low glitch rejected in START
        fe0 = fe_cnt; vc0 = vc;
        tick();
        rx = 1'b0;
        repeat (4) tick();
        rx = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("t2_busy_mid", 32'(busy), 32'd1);
        repeat (20) tick();
        @(negedge clk);
        chk("t2_busy_end", 32'(busy), 32'd0);
        chk("t2_valid", 32'(vc - vc0), 32'd0);
        chk("t2_frame_err", 32'(fe_cnt - fe0), 32'd0);
        chk("t2_overrun", 32'(overrun), 32'd0);

        // Low stop bit followed by a long break
        fe0 = fe_cnt; vc0 = vc;
        send_byte(8'h3C, 1'b0);
        repeat (40 * C) tick();
        @(negedge clk);
        chk("t3_frame_err_pulses", 32'(fe_cnt - fe0), 32'd1);
        chk("t3_busy_in_break", 32'(busy), 32'd1);
        chk("t3_valid", 32'(vc - vc0), 32'd0);
        tick();
        rx = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        chk("t3_busy_after", 32'(busy), 32'd0);

        // Stalled consumer: second byte overruns
        rx_ready = 1'b0;
        sb.push_back(8'h11);
        send_byte(8'h11, 1'b1);
        repeat (4) tick();
        send_byte(8'h22, 1'b1);
        repeat (8) tick();
        @(negedge clk);
        chk("t4_valid_held", 32'(rx_valid), 32'd1);
        chk("t4_data_held", 32'(rx_data), 32'h11);
        chk("t4_overrun_set", 32'(overrun), 32'd1);
        tick();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("t4_valid_clr", 32'(rx_valid), 32'd0);
        chk("t4_overrun_clr", 32'(overrun), 32'd0);
        chk("t4_drained", 32'(sb.size()), 32'd0);

        // Handshake lands exactly in the completion cycle of the next byte
        sb.push_back(8'h11);
        sb.push_back(8'h22);
        send_byte(8'h11, 1'b1);
        repeat (4) tick();
        fork
            send_byte(8'h22, 1'b1);
            begin
                tick();
                repeat (LAT - 1) tick();
                rx_ready = 1'b1;
                tick();
                rx_ready = 1'b0;
            end
        join
        repeat (4) tick();
        @(negedge clk);
        chk("t5_valid", 32'(rx_valid), 32'd1);
        chk("t5_data", 32'(rx_data), 32'h22);
        chk("t5_overrun", 32'(overrun), 32'd0);
        tick();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        repeat (2) tick();

        // Reset during data bit 4, then a clean frame
        rx_ready = 1'b1;
        fe0 = fe_cnt;
        fork
            send_byte(8'hFF, 1'b1);
            begin
                tick();
                repeat (5 * C + 8) tick();
                rst_n = 1'b0;
                @(negedge clk);
                chk("t6_rst_busy", 32'(busy), 32'd0);
                chk("t6_rst_valid", 32'(rx_valid), 32'd0);
                chk("t6_rst_data", 32'(rx_data), 32'h00);
                tick();
                rst_n = 1'b1;
            end
        join
        repeat (4) tick();
        vc0 = vc;
        sb.push_back(8'h5A);
        send_byte(8'h5A, 1'b1);
        repeat (20) tick();
        @(negedge clk);
        chk("t6_valid_count", 32'(vc - vc0), 32'd1);
        chk("t6_frame_err", 32'(fe_cnt - fe0), 32'd0);
        chk("t6_overrun", 32'(overrun), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("final_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx_framer.md
UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, means clk cycles per serial bit; legal range is 4..65535.
REQ-002 Port clk, input, 1 bit: the single clock; every flop is clocked on its rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-005 Port rx_data, output, 8 bits: received byte held in the output holding register.
REQ-006 Port rx_valid, output, 1 bit: rx_data holds an unconsumed byte.
REQ-007 Port rx_ready, input, 1 bit: the consumer accepts rx_data when rx_valid && rx_ready.
REQ-008 Port frame_err, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
REQ-009 Port overrun, output, 1 bit: sticky flag set when a byte is lost.
REQ-010 Port busy, output, 1 bit: high whenever state != IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer, named rx_s in this document, whose flops reset to 1; all decisions SHALL use rx_s only.
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP and BREAK, plus a 16-bit bit-timer and a 3-bit bit index.
REQ-013 IDLE: when rx_s==0, the FSM SHALL go to START with the timer cleared.
REQ-014 START: when the timer reaches CLKS_PER_BIT/2-1 (integer division), the FSM SHALL sample rx_s; if 0, go to DATA with the timer cleared and index 0; if 1, treat it as a glitch and return to IDLE with no flags.
REQ-015 DATA: when the timer reaches CLKS_PER_BIT-1, the FSM SHALL sample rx_s, shift it in LSB-first ({rx_s, shreg[7:1]}), clear the timer and increment the index; after the sample taken at index 7 it SHALL go to STOP.
REQ-016 STOP, at timer==CLKS_PER_BIT-1 with rx_s==1: the FSM SHALL complete the byte (REQ-018) and go to IDLE.
REQ-017 STOP, at timer==CLKS_PER_BIT-1 with rx_s==0: the FSM SHALL pulse frame_err for 1 cycle, discard the byte, leave rx_valid unchanged and go to BREAK; BREAK SHALL go to IDLE on the first cycle rx_s==1.
REQ-018 Byte completion: if rx_valid==0, or rx_valid && rx_ready in the same cycle, the block SHALL load rx_data from shreg and set rx_valid=1 on the next edge.
REQ-019 Byte completion with rx_valid==1 and rx_ready==0: rx_data SHALL keep the old byte, the new byte SHALL be dropped, and overrun SHALL be set.
REQ-020 rx_valid SHALL clear on the edge after rx_valid && rx_ready unless REQ-018 reloads it in that cycle; rx_data SHALL be stable while rx_valid==1.
REQ-021 overrun SHALL clear on a handshake (rx_valid && rx_ready); if a handshake and an overrun event occur in the same cycle, the handshake reloads per REQ-018 and overrun is not set.
REQ-022 Latency: rx_valid SHALL rise exactly 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 2 clk edges after the first rx low edge that leads to a completed frame; this total is 2 synchronizer edges, one IDLE->START transition edge, the START wait and the 9 DATA/STOP bit times, plus one output-register edge.
REQ-023 rx_ready SHALL have no effect on FSM timing, so reception continues while the output is stalled.

Reset
REQ-024 While rst_n==0, asynchronously: state=IDLE, timer=0, index=0, shreg=0, rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, busy=0, synchronizer=1.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no flags; after rst_n rises the block SHALL need rx_s high before it can start (rx_s resets to 1, so a line held low starts a frame only after the synchronizer samples it).

Verification (bench with CLKS_PER_BIT=16)
REQ-026 Send 8'hA5 with a valid stop bit and rx_ready=1 -> rx_valid for 1 cycle with rx_data=8'hA5, frame_err=0, overrun=0, and rise at the REQ-022 cycle count.
REQ-027 Pulse rx low for 4 cycles -> START rejects it as a glitch, busy returns to 0, and no rx_valid, frame_err or overrun.
REQ-028 Send 8'h3C with the stop bit low and the line held low for 40 bit times -> one frame_err pulse, the FSM stays in BREAK until rx goes high, and no rx_valid.
REQ-029 rx_ready=0; send 8'h11 then 8'h22 -> rx_data=8'h11 and overrun=1; then assert rx_ready for 1 cycle -> rx_valid=0 and overrun=0.
REQ-030 rx_ready=0; send 8'h11, then raise rx_ready exactly in the completion cycle of 8'h22 -> rx_data=8'h22, rx_valid stays 1, and overrun=0.
REQ-031 Assert rst_n=0 during data bit 4 of 8'hFF, release it, then send 8'h5A -> only 8'h5A is received, with no flags set.
